// File: rtl/panda_mem_pkg.sv
// panda_mem_pkg: shared types for the instruction/data memory arbiter.
package panda_mem_pkg;
  typedef enum logic {PORT_INSTR, PORT_DATA} mem_port_e;
  typedef enum logic {ARB_RR, ARB_DATA_PRIO} arb_mode_e;
  typedef struct packed {
    logic      valid;
    mem_port_e port;
  } mem_owner_t;
endpackage

// File: rtl/panda_rr_arb2.sv
// panda_rr_arb2: two-way round-robin or data-priority arbiter; bit 0 = instr, bit 1 = data.
module panda_rr_arb2
  import panda_mem_pkg::*;
#(
  parameter arb_mode_e Mode = ARB_RR
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  mem_port_e last_q, last_d;
  logic pick_data;
  always_comb begin
    pick_data = (Mode == ARB_DATA_PRIO) || (last_q == PORT_INSTR);
    gnt_o = rst_i ? 2'b00 : (req_i == 2'b11) ? (pick_data ? 2'b10 : 2'b01) : req_i;
    last_d = gnt_o[1] ? PORT_DATA : gnt_o[0] ? PORT_INSTR : last_q;
  end
  // Reset to DATA so the first conflict after reset goes to the boot fetch.
  always_ff @(posedge clk_i)
    if (rst_i) last_q <= PORT_DATA;
    else last_q <= last_d;
endmodule

// File: rtl/panda_mem_arbiter.sv
// panda_mem_arbiter: shares one single-port RAM between fetch and load/store ports,
// tracking read ownership through the RAM read latency.
module panda_mem_arbiter
  import panda_mem_pkg::*;
#(
  parameter int        AddrWidth   = 5,
  parameter int        ReadLatency = 1,
  parameter arb_mode_e ArbMode     = ARB_RR
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 instr_req_i,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  input  logic                 data_req_i,
  input  logic [31:0]          data_addr_i,
  input  logic [3:0]           data_we_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 mem_ce_o,
  output logic [3:0]           mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i
);
  logic [1:0] gnt;
  mem_owner_t own_d, own_out;
  mem_owner_t pipe_q [ReadLatency];
  logic unused_addr;
  assign unused_addr = ^{instr_addr_i[31:AddrWidth+2], instr_addr_i[1:0],
                         data_addr_i[31:AddrWidth+2], data_addr_i[1:0]};
  panda_rr_arb2 #(.Mode(ArbMode)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({data_req_i, instr_req_i}),
    .gnt_o (gnt)
  );
  always_comb begin
    instr_gnt_o = gnt[0];
    data_gnt_o = gnt[1];
    mem_ce_o = |gnt;
    mem_we_o = gnt[1] ? data_we_i : 4'b0;
    mem_addr_o = gnt[1] ? data_addr_i[AddrWidth+1:2] : instr_addr_i[AddrWidth+1:2];
    mem_wdata_o = data_wdata_i;
    own_d = '{valid: |gnt, port: (gnt[1] ? PORT_DATA : PORT_INSTR)};
    own_out = pipe_q[ReadLatency-1];
    instr_rvalid_o = !rst_i && own_out.valid && own_out.port == PORT_INSTR;
    data_rvalid_o = !rst_i && own_out.valid && own_out.port == PORT_DATA;
    instr_rdata_o = instr_rvalid_o ? mem_rdata_i : 32'b0;
    data_rdata_o = data_rvalid_o ? mem_rdata_i : 32'b0;
  end
  // Owner shift register aligned with the RAM read latency; reset drops in-flight reads.
  always_ff @(posedge clk_i)
    if (rst_i) begin
      for (int i = 0; i < ReadLatency; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= own_d;
      for (int i = 1; i < ReadLatency; i++) pipe_q[i] <= pipe_q[i-1];
    end
endmodule

// File: tb/tb_panda_mem_arbiter.sv
// tb_panda_mem_arbiter: checks a round-robin/latency-1 and a data-priority/latency-2 arbiter
// against a cycle-indexed response scoreboard and a reference memory image.
module tb_panda_mem_arbiter;
  import panda_mem_pkg::*;
  localparam int AW = 5;
  localparam int NC = 1024;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic ireq[2], dreq[2], igt[2], dgt[2], irv[2], drv[2], mce[2];
  logic [31:0] iaddr[2], daddr[2], dwd[2], ird[2], drd[2], mwd[2], mrd[2], rd1[2], rd2[2];
  logic [3:0] dwe[2], mwe[2];
  logic [AW-1:0] maddr[2];
  logic [31:0] ram[2][32], rm[2][32];
  logic [1:0] ev[2][NC];
  logic [31:0] ed[2][NC];
  bit lst[2], pi[2], pd[2];
  int lat[2] = '{1, 2};
  bit prio[2] = '{0, 1};
  int cyc = 0, ncmp = 0, nfail = 0;

  panda_mem_arbiter #(.AddrWidth(AW), .ReadLatency(1), .ArbMode(ARB_RR)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(ireq[0]), .instr_addr_i(iaddr[0]), .instr_gnt_o(igt[0]),
    .instr_rvalid_o(irv[0]), .instr_rdata_o(ird[0]),
    .data_req_i(dreq[0]), .data_addr_i(daddr[0]), .data_we_i(dwe[0]), .data_wdata_i(dwd[0]),
    .data_gnt_o(dgt[0]), .data_rvalid_o(drv[0]), .data_rdata_o(drd[0]),
    .mem_ce_o(mce[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwd[0]),
    .mem_rdata_i(mrd[0]));
  panda_mem_arbiter #(.AddrWidth(AW), .ReadLatency(2), .ArbMode(ARB_DATA_PRIO)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(ireq[1]), .instr_addr_i(iaddr[1]), .instr_gnt_o(igt[1]),
    .instr_rvalid_o(irv[1]), .instr_rdata_o(ird[1]),
    .data_req_i(dreq[1]), .data_addr_i(daddr[1]), .data_we_i(dwe[1]), .data_wdata_i(dwd[1]),
    .data_gnt_o(dgt[1]), .data_rvalid_o(drv[1]), .data_rdata_o(drd[1]),
    .mem_ce_o(mce[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwd[1]),
    .mem_rdata_i(mrd[1]));

  function automatic logic [31:0] pre(input int i);
    return (i == 3) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i) * 32'h00010203;
  endfunction

  // Read-first single-port RAM per DUT; contents restored on reset.
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) ram[k][i] <= pre(i);
      end else if (mce[k]) begin
        rd1[k] <= ram[k][maddr[k]];
        for (int b = 0; b < 4; b++)
          if (mwe[k][b]) ram[k][maddr[k]][8*b +: 8] <= mwd[k][8*b +: 8];
      end
      rd2[k] <= rd1[k];
    end
  assign mrd[0] = rd1[0];
  assign mrd[1] = rd2[1];

  task automatic chk(input int k, input string tag, input logic [31:0] o, input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL dut%0d %s cyc %0d: got %h expected %h", k, tag, cyc, o, e);
    end
  endtask

  task automatic model(input int k);
    logic wi, wd;
    logic [AW-1:0] a;
    if (rst) begin
      chk(k, "rst igt", igt[k], 0);
      chk(k, "rst dgt", dgt[k], 0);
      chk(k, "rst ce", mce[k], 0);
      chk(k, "rst we", mwe[k], 0);
      chk(k, "rst irv", irv[k], 0);
      chk(k, "rst drv", drv[k], 0);
      chk(k, "rst ird", ird[k], 0);
      chk(k, "rst drd", drd[k], 0);
      lst[k] = 1;
      pi[k] = 0;
      pd[k] = 0;
      for (int i = cyc + 1; i <= cyc + 2; i++) ev[k][i] = 2'b00;
      for (int i = 0; i < 32; i++) rm[k][i] = pre(i);
    end else begin
      wi = ireq[k] && (!dreq[k] || (!prio[k] && lst[k]));
      wd = dreq[k] && !wi;
      a = wd ? daddr[k][AW+1:2] : iaddr[k][AW+1:2];
      chk(k, "igt", igt[k], wi);
      chk(k, "dgt", dgt[k], wd);
      chk(k, "ce", mce[k], wi | wd);
      chk(k, "we", mwe[k], wd ? dwe[k] : 4'b0);
      if (wi | wd) chk(k, "addr", maddr[k], a);
      chk(k, "irv", irv[k], ev[k][cyc][0]);
      chk(k, "drv", drv[k], ev[k][cyc][1]);
      chk(k, "ird", ird[k], ev[k][cyc][0] ? ed[k][cyc] : 32'b0);
      chk(k, "drd", drd[k], ev[k][cyc][1] ? ed[k][cyc] : 32'b0);
      if (wi | wd) begin
        ev[k][cyc+lat[k]] = wd ? 2'b10 : 2'b01;
        ed[k][cyc+lat[k]] = rm[k][a];
        if (wd)
          for (int b = 0; b < 4; b++)
            if (dwe[k][b]) rm[k][a][8*b +: 8] = dwd[k][8*b +: 8];
        lst[k] = wd;
      end
      pi[k] = ireq[k] && !wi;
      pd[k] = dreq[k] && !wd;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model(0);
    model(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                     input logic [3:0] we, input logic [31:0] wd);
    for (int k = 0; k < 2; k++) begin
      ireq[k] = ir;
      iaddr[k] = ia;
      dreq[k] = dr;
      daddr[k] = da;
      dwe[k] = we;
      dwd[k] = wd;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NC; i++) ev[k][i] = 2'b00;
    set(1, 32'h0C, 1, 32'h20, 4'h0, 32'h0);
    rst = 1;
    repeat (3) tick();
    rst = 0;
    repeat (4) tick();
    set(1, 32'h0C, 0, 32'h20, 4'h0, 32'h0);
    tick();
    set(0, 0, 0, 0, 4'h0, 0);
    repeat (3) tick();
    set(1, 32'h0C, 0, 0, 4'h0, 0);
    tick();
    set(0, 0, 0, 0, 4'h0, 0);
    repeat (3) tick();
    set(0, 0, 1, 32'h10, 4'hF, 32'h12345678);
    tick();
    set(0, 0, 1, 32'h10, 4'h0, 32'h0);
    tick();
    set(0, 0, 0, 0, 4'h0, 0);
    repeat (3) tick();
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pi[k]) begin
          ireq[k] = ($urandom_range(0, 3) != 0);
          iaddr[k] = $urandom;
        end
        if (!pd[k]) begin
          dreq[k] = ($urandom_range(0, 3) != 0);
          daddr[k] = $urandom;
          dwe[k] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
          dwd[k] = $urandom;
        end
      end
      tick();
    end
    repeat (4) begin
      for (int k = 0; k < 2; k++) begin
        if (!pi[k]) ireq[k] = 0;
        if (!pd[k]) dreq[k] = 0;
      end
      tick();
    end
    set(1, 32'h0C, 0, 0, 4'h0, 0);
    tick();
    set(0, 0, 0, 0, 4'h0, 0);
    rst = 1;
    tick();
    rst = 0;
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
